// File: rtl/snake_control.sv
// snake_control: Moore sequencer driving the snake datapath (init, food, move/shift, grow, erase, death).
// Build option: define SNAKE_GROW_EN to let a food hit grow the snake; otherwise length stays INIT_LEN.
module snake_control #(
  parameter int INIT_LEN = 4,
  parameter int MAX_LEN  = 64,
  parameter int MOVE_DIV = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        isDead,
  input  logic        inc_length,
  output logic        ld_head,
  output logic        ld_q_def,
  output logic        inc_address,
  output logic        rst_address,
  output logic        update_head,
  output logic        ld_head_into_prev,
  output logic        ld_q_into_curr,
  output logic        ld_prev_into_q,
  output logic        ld_curr_into_prev,
  output logic        draw_q,
  output logic        draw_curr,
  output logic        food_en,
  output logic        check_inc,
  output logic        lock,
  output logic [1:0]  cnt_status,
  output logic [2:0]  dir,
  output logic [2:0]  colour,
  output logic [10:0] length,
  output logic        dead
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [MW-1:0] MV_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [10:0]   LEN_INIT = 11'(INIT_LEN);
  localparam logic [10:0]   LEN_CAP  = 11'(MAX_LEN);
  localparam logic [2:0]    DIR_UP   = 3'b100;
  localparam logic [2:0]    DIR_DOWN = 3'b110;
  localparam logic [2:0]    DIR_LEFT = 3'b000;
  localparam logic [2:0]    DIR_RIGHT = 3'b001;

  typedef enum logic [3:0] {
    S_INIT, S_FOOD, S_WAIT, S_UPD, S_HPREV, S_RD, S_LDC, S_WR,
    S_RB, S_DRAW, S_SHIFT, S_CHK, S_ERASE, S_DEAD
`ifdef SNAKE_GROW_EN
    , S_GROW
`endif
  } state_t;

  typedef struct packed {
    logic       ld_head;
    logic       ld_q_def;
    logic       inc_address;
    logic       rst_address;
    logic       update_head;
    logic       ld_head_into_prev;
    logic       ld_q_into_curr;
    logic       ld_prev_into_q;
    logic       ld_curr_into_prev;
    logic       draw_q;
    logic       draw_curr;
    logic       food_en;
    logic       check_inc;
    logic       lock;
    logic [1:0] cnt_status;
    logic [2:0] colour;
    logic       dead;
  } outs_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [10:0]   idx_q, idx_d;
  logic [MW-1:0] mv_q, mv_d;
  logic [10:0]   len_q, len_d;
  logic          tofood_q, tofood_d;
  logic [2:0]    dir_q, dir_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    req_s;
  logic          req_v_s;
  outs_t         outs_q;

  // INIT phases: cnt 0 = idle after reset, cnt 1 = default body writes, cnt 2 = address rewind.
  function automatic outs_t decode(input state_t st, input logic [1:0] cnt, input logic [10:0] idx);
    outs_t o;
    o = '0;
    case (st)
      S_INIT: begin
        o.ld_head     = (cnt == 2'd1) && (idx == 11'd0);
        o.ld_q_def    = (cnt == 2'd1);
        o.inc_address = (cnt == 2'd1);
        o.rst_address = (cnt == 2'd2);
      end
      S_FOOD:  begin o.food_en = 1'b1; o.cnt_status = cnt; o.colour = 3'b100; end
      S_WAIT:  o.lock = 1'b1;
      S_UPD:   begin o.update_head = 1'b1; o.rst_address = 1'b1; end
      S_HPREV: o.ld_head_into_prev = 1'b1;
      S_LDC:   o.ld_q_into_curr = 1'b1;
      S_WR:    o.ld_prev_into_q = 1'b1;
      S_DRAW:  begin o.draw_q = 1'b1; o.cnt_status = cnt; o.colour = 3'b010; end
      S_SHIFT: begin o.ld_curr_into_prev = 1'b1; o.inc_address = 1'b1; end
      S_CHK:   o.check_inc = 1'b1;
`ifdef SNAKE_GROW_EN
      S_GROW:  o.ld_prev_into_q = 1'b1;
`endif
      S_ERASE: begin o.draw_curr = 1'b1; o.cnt_status = cnt; o.colour = 3'b000; end
      S_DEAD:  o.dead = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [2:0] opposite(input logic [2:0] d);
    return {d[2], d[2] & ~d[1], ~d[2] & ~d[0]};
  endfunction

  // Next state, phase counters and address mirror.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mv_d     = mv_q;
    len_d    = len_q;
    tofood_d = tofood_q;
    if (outs_q.rst_address) idx_d = 11'd0;
    else if (outs_q.inc_address) idx_d = idx_q + 11'd1;
    else idx_d = idx_q;
    if (isDead && (state_q != S_INIT)) begin
      state_d = S_DEAD;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        S_INIT: begin
          case (cnt_q)
            2'd0:    cnt_d = 2'd1;
            2'd1:    cnt_d = (idx_q == LEN_INIT - 11'd1) ? 2'd2 : 2'd1;
            2'd2:    begin state_d = S_FOOD; cnt_d = 2'd0; end
            default: cnt_d = 2'd0;
          endcase
        end
        S_FOOD: begin
          if (cnt_q == 2'd3) begin state_d = S_WAIT; cnt_d = 2'd0; end
          else cnt_d = cnt_q + 2'd1;
        end
        S_WAIT: begin
          if (mv_q == MV_LAST) begin mv_d = MW'(0); state_d = S_UPD; end
          else mv_d = mv_q + MW'(1);
        end
        S_UPD:   state_d = S_HPREV;
        S_HPREV: state_d = S_RD;
        S_RD:    state_d = S_LDC;
        S_LDC:   state_d = S_WR;
        S_WR:    state_d = S_RB;
        S_RB:    begin state_d = S_DRAW; cnt_d = 2'd0; end
        S_DRAW: begin
          if (cnt_q == 2'd3) begin state_d = S_SHIFT; cnt_d = 2'd0; end
          else cnt_d = cnt_q + 2'd1;
        end
        S_SHIFT: state_d = (idx_q == len_q - 11'd1) ? S_CHK : S_RD;
        S_CHK: begin
`ifdef SNAKE_GROW_EN
          if (inc_length && (len_q < LEN_CAP)) state_d = S_GROW;
          else begin state_d = S_ERASE; tofood_d = inc_length; end
`else
          state_d  = S_ERASE;
          tofood_d = 1'b0;
`endif
        end
`ifdef SNAKE_GROW_EN
        S_GROW: begin len_d = len_q + 11'd1; state_d = S_FOOD; cnt_d = 2'd0; end
`endif
        S_ERASE: begin
          if (cnt_q == 2'd3) begin
            state_d  = tofood_q ? S_FOOD : S_WAIT;
            cnt_d    = 2'd0;
            tofood_d = 1'b0;
          end else cnt_d = cnt_q + 2'd1;
        end
        S_DEAD:  state_d = S_DEAD;
        default: begin state_d = S_INIT; cnt_d = 2'd0; end
      endcase
    end
  end

  // Direction request arbitration; dir only takes the pending value when a move starts.
  always_comb begin
    req_v_s = 1'b1;
    if (key_up) req_s = DIR_UP;
    else if (key_down) req_s = DIR_DOWN;
    else if (key_left) req_s = DIR_LEFT;
    else if (key_right) req_s = DIR_RIGHT;
    else begin req_s = DIR_RIGHT; req_v_s = 1'b0; end
    if (req_v_s && (req_s != opposite(dir_q))) pend_d = req_s;
    else pend_d = pend_q;
    if ((state_q == S_WAIT) && (state_d == S_UPD)) dir_d = pend_q;
    else dir_d = dir_q;
  end

`ifndef SNAKE_GROW_EN
  logic unused_grow_s;
  assign unused_grow_s = inc_length ^ (len_q == LEN_CAP);
`endif

  // State and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= 2'd0;
      idx_q    <= 11'd0;
      mv_q     <= MW'(0);
      len_q    <= LEN_INIT;
      tofood_q <= 1'b0;
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      outs_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mv_q     <= mv_d;
      len_q    <= len_d;
      tofood_q <= tofood_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      outs_q   <= decode(state_d, cnt_d, idx_d);
    end
  end

  assign ld_head           = outs_q.ld_head;
  assign ld_q_def          = outs_q.ld_q_def;
  assign inc_address       = outs_q.inc_address;
  assign rst_address       = outs_q.rst_address;
  assign update_head       = outs_q.update_head;
  assign ld_head_into_prev = outs_q.ld_head_into_prev;
  assign ld_q_into_curr    = outs_q.ld_q_into_curr;
  assign ld_prev_into_q    = outs_q.ld_prev_into_q;
  assign ld_curr_into_prev = outs_q.ld_curr_into_prev;
  assign draw_q            = outs_q.draw_q;
  assign draw_curr         = outs_q.draw_curr;
  assign food_en           = outs_q.food_en;
  assign check_inc         = outs_q.check_inc;
  assign lock              = outs_q.lock;
  assign cnt_status        = outs_q.cnt_status;
  assign colour            = outs_q.colour;
  assign dead              = outs_q.dead;
  assign dir               = dir_q;
  assign length            = len_q;

endmodule

// File: tb/tb_snake_control.sv
// Randomized bench for snake_control: a phase-sequence reference model predicts every output each cycle.
module tb_snake_control;
  localparam int INIT_LEN = 4;
  localparam int MAX_LEN  = 6;
  localparam int MOVE_DIV = 16;
`ifdef SNAKE_GROW_EN
  localparam bit GROW_EN = 1'b1;
`else
  localparam bit GROW_EN = 1'b0;
`endif

  localparam int K_IDLE = 0, K_INITW = 1, K_RSTA = 2, K_FOOD = 3, K_WAIT = 4, K_UPD = 5,
                 K_HPREV = 6, K_RD = 7, K_LDC = 8, K_WR = 9, K_RB = 10, K_DRAW = 11,
                 K_SHIFT = 12, K_CHK = 13, K_GROW = 14, K_ERASE = 15, K_DEAD = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic isDead = 1'b0, inc_length = 1'b0;
  logic ld_head, ld_q_def, inc_address, rst_address, update_head, ld_head_into_prev;
  logic ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_q, draw_curr;
  logic food_en, check_inc, lock, dead;
  logic [1:0]  cnt_status;
  logic [2:0]  dir, colour;
  logic [10:0] length;

  snake_control #(.INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN), .MOVE_DIV(MOVE_DIV)) dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .isDead(isDead), .inc_length(inc_length),
    .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address), .rst_address(rst_address),
    .update_head(update_head), .ld_head_into_prev(ld_head_into_prev),
    .ld_q_into_curr(ld_q_into_curr), .ld_prev_into_q(ld_prev_into_q),
    .ld_curr_into_prev(ld_curr_into_prev), .draw_q(draw_q), .draw_curr(draw_curr),
    .food_en(food_en), .check_inc(check_inc), .lock(lock),
    .cnt_status(cnt_status), .dir(dir), .colour(colour), .length(length), .dead(dead)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int qk[$], qs[$];
  int mlen;
  logic [2:0] mdir, mpend;
  int key_mode = 0, inc_mode = 0, last_k = 0;
  logic [3:0] key_fix = 4'd0;
  bit rst_req = 1'b0, dead_req = 1'b0;

  task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] got_vec();
    return {length, dir, dead, colour, cnt_status, lock, check_inc, food_en, draw_curr, draw_q,
            ld_curr_into_prev, ld_prev_into_q, ld_q_into_curr, ld_head_into_prev, update_head,
            rst_address, inc_address, ld_q_def, ld_head};
  endfunction

  // Strobe bits: 0 ld_head,1 ld_q_def,2 inc_address,3 rst_address,4 update_head,5 ld_head_into_prev,
  // 6 ld_q_into_curr,7 ld_prev_into_q,8 ld_curr_into_prev,9 draw_q,10 draw_curr,11 food_en,12 check_inc,13 lock
  function automatic logic [33:0] expv(input int k, input int s);
    logic [13:0] st;
    logic [1:0]  cs;
    logic [2:0]  col;
    logic        dd;
    st = 14'd0; cs = 2'd0; col = 3'd0; dd = 1'b0;
    case (k)
      K_INITW: begin st[1] = 1'b1; st[2] = 1'b1; st[0] = (s == 0); end
      K_RSTA:  st[3] = 1'b1;
      K_FOOD:  begin st[11] = 1'b1; cs = 2'(s); col = 3'b100; end
      K_WAIT:  st[13] = 1'b1;
      K_UPD:   begin st[4] = 1'b1; st[3] = 1'b1; end
      K_HPREV: st[5] = 1'b1;
      K_LDC:   st[6] = 1'b1;
      K_WR:    st[7] = 1'b1;
      K_DRAW:  begin st[9] = 1'b1; cs = 2'(s); col = 3'b010; end
      K_SHIFT: begin st[8] = 1'b1; st[2] = 1'b1; end
      K_CHK:   st[12] = 1'b1;
      K_GROW:  st[7] = 1'b1;
      K_ERASE: begin st[10] = 1'b1; cs = 2'(s); end
      K_DEAD:  dd = 1'b1;
      default: st = 14'd0;
    endcase
    return {11'(mlen), mdir, dd, col, cs, st};
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_IDLE: return "idle"; K_INITW: return "init_write"; K_RSTA: return "init_rewind";
      K_FOOD: return "food"; K_WAIT: return "wait"; K_UPD: return "upd"; K_HPREV: return "hprev";
      K_RD: return "rd"; K_LDC: return "ldc"; K_WR: return "wr"; K_RB: return "rb";
      K_DRAW: return "draw"; K_SHIFT: return "shift"; K_CHK: return "chk"; K_GROW: return "grow";
      K_ERASE: return "erase"; K_DEAD: return "dead";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    case (d)
      3'b100:  return 3'b110;
      3'b110:  return 3'b100;
      3'b000:  return 3'b001;
      3'b001:  return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  task automatic push(input int k, input int s);
    qk.push_back(k); qs.push_back(s);
  endtask
  task automatic push_food();  for (int c = 0; c < 4; c++) push(K_FOOD, c);  endtask
  task automatic push_erase(); for (int c = 0; c < 4; c++) push(K_ERASE, c); endtask
  task automatic push_wait();
    for (int i = 0; i < MOVE_DIV; i++) push(K_WAIT, (i == MOVE_DIV - 1) ? 1 : 0);
  endtask
  task automatic push_move();
    push(K_UPD, 0); push(K_HPREV, 0);
    for (int i = 0; i < mlen; i++) begin
      push(K_RD, 0); push(K_LDC, 0); push(K_WR, 0); push(K_RB, 0);
      for (int c = 0; c < 4; c++) push(K_DRAW, c);
      push(K_SHIFT, 0);
    end
    push(K_CHK, 0);
  endtask

  task automatic model_reset();
    mlen = INIT_LEN; mdir = 3'b001; mpend = 3'b001;
    qk.delete(); qs.delete();
    push(K_IDLE, 0);
    for (int i = 0; i < INIT_LEN; i++) push(K_INITW, i);
    push(K_RSTA, 0);
    push_food();
    push_wait();
  endtask

  task automatic step();
    int k, s;
    logic [3:0] kv;
    logic [2:0] req, old_p;
    bit rv;
    if (qk.size() == 0) begin
      errors++;
      $display("FAIL model_sync: no expectation left at t=%0t", $time);
      return;
    end
    k = qk.pop_front(); s = qs.pop_front(); last_k = k;
    check_eq(kname(k), got_vec(), expv(k, s));
    case (key_mode)
      1: kv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      2: kv = key_fix;
      default: kv = 4'd0;
    endcase
    {key_up, key_down, key_left, key_right} = kv;
    case (inc_mode)
      1: inc_length = 1'b1;
      2: inc_length = 1'($urandom_range(0, 1));
      default: inc_length = 1'b0;
    endcase
    isDead = 1'b0;
    if (dead_req && k == K_DRAW) begin isDead = 1'b1; dead_req = 1'b0; end
    old_p = mpend; rv = 1'b1; req = 3'b001;
    if (kv[3]) req = 3'b100;
    else if (kv[2]) req = 3'b110;
    else if (kv[1]) req = 3'b000;
    else if (kv[0]) req = 3'b001;
    else rv = 1'b0;
    if (rv && req != reverse_of(mdir)) mpend = req;
    if (isDead) begin
      qk.delete(); qs.delete(); push(K_DEAD, 0);
    end else begin
      case (k)
        K_WAIT: if (s == 1) begin mdir = old_p; push_move(); end
        K_CHK: begin
          if (GROW_EN && inc_length && mlen < MAX_LEN) begin push(K_GROW, 0); push_food(); end
          else if (GROW_EN && inc_length) begin push_erase(); push_food(); end
          else push_erase();
          push_wait();
        end
        K_GROW: mlen++;
        K_DEAD: push(K_DEAD, 0);
        default: ;
      endcase
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    {key_up, key_down, key_left, key_right} = 4'd0;
    isDead = 1'b0; inc_length = 1'b0;
    model_reset();
    #1;
    check_eq("async_reset", got_vec(), expv(K_IDLE, 0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (rst_req && last_k == K_WR) begin
        rst_req = 1'b0;
        #2;
        apply_reset();
      end else @(negedge clk);
    end
  endtask

  initial begin
    #3;
    apply_reset();
    run(200);
    key_mode = 2; key_fix = 4'b0010; run(150);
    key_fix = 4'b1000; run(150);
    key_mode = 1; inc_mode = 1; run(600);
    inc_mode = 2; run(400);
    rst_req = 1'b1; run(300);
    dead_req = 1'b1; run(250);
    #2;
    apply_reset();
    run(80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
